alu_share_arb: RTL
==================

# alu_share_arb

Round-robin arbiter and sequencer that shares the single-cycle 32-bit ALU between two requesters, typically the integer pipe (port 0) and the address/branch unit (port 1). Each requester issues an operation with a valid/ready handshake and receives the result and status flags on a separate valid/ready response channel. The block owns the ALU operand and control inputs, registers them at acceptance, captures the ALU result one cycle later, and holds it until the owning requester takes it.

## Interface
- DATA_W, 32, operand/result width; fixed by the ALU.
- OP_W, 4, ALU control width; fixed by the ALU.
- MAX_OP, 4'b1100, highest legal ALU control code.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous active-low.
- req_valid[1:0]  in  2  per-port operation request.
- req_ready[1:0]  out  2  per-port accept; at most one bit high.
- req_a0, req_a1  in  DATA_W  operand A per port.
- req_b0, req_b1  in  DATA_W  operand B per port.
- req_op0, req_op1  in  OP_W  ALU control code per port.
- rsp_valid[1:0]  out  2  per-port response valid; at most one bit high.
- rsp_ready[1:0]  in  2  per-port response accept.
- rsp_result  out  DATA_W  result, shared by both ports, qualified by rsp_valid.
- rsp_zero, rsp_neg, rsp_err  out  1 each  ALU Zero, ALU Negative, illegal-opcode flag.
- alu_a, alu_b  out  DATA_W  registered ALU operands.
- alu_ctrl  out  OP_W  registered ALU control.
- alu_result  in  DATA_W  ALU Result.
- alu_zero, alu_neg  in  1 each  ALU Zero and Negative.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is high, assert req_ready for the granted port only. On that handshake:
  - latch A, B and op into alu_a, alu_b and alu_ctrl;
  - record the grant owner and go to EXEC.
- Grant rule: with one valid port, grant that port. With both valid, grant the port that is not last_grant. last_grant updates at each accepted request.
- EXEC: capture the following, then go to RESP:
  - alu_result into rsp_result;
  - alu_zero into rsp_zero and alu_neg into rsp_neg;
  - rsp_err = (alu_ctrl > MAX_OP).
- Illegal opcode: the ALU still executes and returns 0. The result is forwarded with rsp_err = 1. There is no other side effect.
- RESP: rsp_valid[owner] = 1, and rsp_result and the flags are held stable. On rsp_ready[owner], go to IDLE.
- rsp_ready of the non-owner port is ignored. req_valid is ignored outside IDLE, and req_ready is 0 outside IDLE.
- A requester may drop req_valid without a handshake. No request is accepted implicitly.
- Reset values:
  - state = IDLE, last_grant = 1, so port 0 wins the first contention;
  - req_ready = 0, rsp_valid = 0;
  - alu_a = alu_b = 0, alu_ctrl = 0;
  - rsp_result = 0, all flags 0, busy = 0.
- Reset mid-operation: the in-flight operation is dropped and no response is issued. last_grant returns to 1.

## Timing
- req_ready is combinational from state, req_valid and last_grant. It has no path from rsp_ready.
- Request handshake at edge T gives:
  - alu_* valid in cycle T+1 (EXEC);
  - rsp_valid high from cycle T+2;
  - earliest response handshake at edge T+2, and earliest next acceptance at edge T+3.
- Maximum throughput is one operation per 3 cycles. Response backpressure extends RESP indefinitely.
- alu_a, alu_b and alu_ctrl change only at request acceptance and hold their values through IDLE.
- A port may re-assert req_valid while its own response is pending. It is not accepted before the FSM returns to IDLE.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention, last_grant is not used, and port 1 can starve.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Test plan
- Single request, port 0, A=5, B=3, op=0000, rsp_ready held 1 -> rsp_valid[0] at T+2, rsp_result=8, zero=0, neg=0, err=0.
- Both ports valid continuously out of reset; port 0 op=0001 with A=3, B=3; port 1 op=0101 with A=0xFFFFFFFF, B=1 -> grants alternate 0,1,0,1. Port 0 gets result 0 with zero=1. Port 1 gets result 1 (SLT -1<1).
- Port 1 response backpressured (rsp_ready[1]=0 for 10 cycles) while port 0 is valid -> req_ready[0] stays 0 and rsp_result stays stable. Port 0 is accepted the cycle after the port 1 handshake.
- Illegal op 4'b1111 on port 0 -> rsp_result=0, rsp_zero=1, rsp_err=1.
- rst_n low during EXEC -> no rsp_valid, all outputs at reset values the cycle after. The next contention grants port 0.
- ALU_ARB_FIXED_PRIO_EN build, both ports valid for 6 operations -> all 6 are granted to port 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one single-cycle ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module alu_share_arb #(
    parameter int              DATA_W = 32,
    parameter int              OP_W   = 4,
    parameter logic [OP_W-1:0] MAX_OP = 4'b1100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   owner;
    logic   grant;
    logic   accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant;
`endif

    // grant is only meaningful when at least one req_valid bit is set
    always_comb begin
        grant     = 1'b0;
        req_ready = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~req_valid[0];
`else
        if (req_valid == 2'b11)
            grant = ~last_grant;
        else
            grant = ~req_valid[0];
`endif
        if (state == IDLE && |req_valid)
            req_ready[grant] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant ? req_a1  : req_a0;
                        alu_b      <= grant ? req_b1  : req_b0;
                        alu_ctrl   <= grant ? req_op1 : req_op0;
                        owner      <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_neg    <= alu_neg;
                    rsp_err    <= (alu_ctrl > MAX_OP);
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
